button_conditioner: RTL

Front end for the up/down counter's `sb[1:0]` input. It takes the two raw, bouncing, asynchronous push-button lines and produces clean, debounced levels on `sb[1:0]`, plus one-cycle press pulses. It sits between the board pins and the counter, and both share `clk`, `rst` and `en`.

---
 rtl/button_conditioner_pkg.sv | 15 +
 rtl/button_conditioner_channel.sv | 109 ++++++++++
 rtl/button_conditioner.sv | 48 ++++
 3 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button front end: debounce FSM state
// encoding and default timing parameters, reused by the counter bench and top.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        QUAL_PRESS   = 2'b01,
        PRESSED      = 2'b10,
        QUAL_RELEASE = 2'b11
    } db_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage : button_conditioner_pkg

// File: rtl/button_conditioner_channel.sv
// One push-button channel: synchronizer, debounce FSM with qualification
// counter, registered level and a one-cycle press strobe.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic btn_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   syn;
    db_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;

    // The synchronizer runs regardless of en so the pipeline never holds stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (en_i) begin
            unique case (state_q)
                RELEASED: begin
                    if (syn) begin
                        state_d = QUAL_PRESS;
                        cnt_d   = CNT_ONE;
                    end
                end
                QUAL_PRESS: begin
                    if (!syn) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!syn) begin
                        state_d = QUAL_RELEASE;
                        cnt_d   = CNT_ONE;
                    end
                end
                QUAL_RELEASE: begin
                    if (syn) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = RELEASED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end
            endcase
        end
        level_d = (state_d == PRESSED) || (state_d == QUAL_RELEASE);
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset here is synchronous.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o = level_q;
    // A strobe that lands just as en drops is suppressed rather than leaked.
    assign pulse_o = pulse_q & en_i;

endmodule : debounce_channel

// File: rtl/button_conditioner.sv
// Top level: two independent debounce channels feeding sb[1:0] and the press
// strobes of the up/down counter. No arbitration; sb=2'b11 is legal.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] sb,
    output logic       up_pulse,
    output logic       down_pulse
);

    logic up_level;
    logic down_level;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_up (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .btn_i   (btn_up),
        .level_o (up_level),
        .pulse_o (up_pulse)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
    ) u_down (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .btn_i   (btn_down),
        .level_o (down_level),
        .pulse_o (down_pulse)
    );

    assign sb = {up_level, down_level};

endmodule : button_conditioner
